braun_mult_pipe: RTL and testbench

//   Parametrised, pipelined Braun array multiplier. Next generation of the combinational 8x8 unsigned multiplier.

---
 rtl/braun_pkg.sv | 26 ++
 rtl/braun_mult_pipe_row.sv | 38 +++
 rtl/braun_mult_pipe.sv | 173 +++++++++++++++++
 tb/tb_braun_mult_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/braun_pkg.sv
// Shared helpers for the pipelined Braun multiplier: pipeline geometry and
// configuration sanity functions.
package braun_pkg;

  // Number of carry-save pipeline stages (each one evaluates rps adder rows).
  function automatic int braun_stages(input int w, input int rps);
    return w / rps;
  endfunction

  // Cycles from input accept to out_valid: input stage + row stages;
  // the output register holds the final ripple adder.
  function automatic int braun_lat(input int w, input int rps);
    return w / rps + 1;
  endfunction

  // Legal configurations: operands of at least 4 bits, rows split evenly.
  function automatic bit braun_cfg_ok(input int w, input int rps);
    return (w >= 4) && (rps > 0) && ((w % rps) == 0);
  endfunction

  // Width of one stage's {sum, carry, a, b, signed, tag} bundle.
  function automatic int braun_bundle_w(input int w, input int tag_w);
    return 4 * w + 1 + tag_w;
  endfunction

endpackage

// File: rtl/braun_mult_pipe_row.sv
// One W-bit carry-save row of a Braun array. Adds a partial-product row to
// the incoming sum/carry vectors, retires the LSB and realigns the rest for
// the next row. In signed mode it applies the Baugh-Wooley bit inversions and
// injects the two correction constants through the free top sum bit.
module braun_row
  import braun_pkg::*;
#(
  parameter int W   = 8,
  parameter int ROW = 0
) (
  input  logic [W-1:0] pp_i,
  input  logic         sgn_i,
  input  logic [W-1:0] sum_i,
  input  logic [W-1:0] cry_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] cry_o,
  output logic         lsb_o
);

  logic [W-1:0] pp;
  logic [W-1:0] fa_s;

  // Full-adder row; sum shifts down one place, carries keep their index.
  always_comb begin
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    pp = '0;
    for (int i = 0; i < W; i++) begin
      // Invert terms where exactly one operand bit is a sign bit.
      pp[i] = pp_i[i] ^ (sgn_i & ((i == W - 1) != (ROW == W - 1)));
    end
    fa_s  = pp ^ sum_i ^ cry_i;
    cry_o = (pp & sum_i) | (pp & cry_i) | (sum_i & cry_i);
    lsb_o = fa_s[0];
    // Row 0 feeds weight 2^W, the last row feeds weight 2^(2W-1).
    sum_o = {sgn_i & ((ROW == 0) || (ROW == W - 1)), fa_s[W-1:1]};
  end

endmodule

// File: rtl/braun_mult_pipe.sv
// Pipelined signed/unsigned Braun array multiplier with valid/ready on both
// sides and a tag carried alongside each operation. The whole pipe freezes
// while the output is stalled; bubbles are not collapsed.
module braun_mult_pipe
  import braun_pkg::*;
#(
  parameter int W              = 8,
  parameter int ROWS_PER_STAGE = 2,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag
);

  localparam int RPS = ROWS_PER_STAGE;
  localparam int S   = braun_stages(W, RPS);

  // Stage 0 holds the raw operands; stage k (1..S) holds the op after k*RPS rows.
  logic             vld_q [0:S];
  logic             vld_d [0:S];
  logic [W-1:0]     a_q   [0:S-1];
  logic [W-1:0]     a_d   [0:S-1];
  logic [W-1:0]     b_q   [0:S-1];
  logic [W-1:0]     b_d   [0:S-1];
  logic             sgn_q [0:S-1];
  logic             sgn_d [0:S-1];
  logic [TAG_W-1:0] tag_q [0:S];
  logic [TAG_W-1:0] tag_d [0:S];
  logic [W-1:0]     sum_q [1:S];
  logic [W-1:0]     sum_d [1:S];
  logic [W-1:0]     cry_q [1:S];
  logic [W-1:0]     cry_d [1:S];
  logic [W-1:0]     lo_q  [1:S];   // product bits already retired by the rows
  logic [W-1:0]     lo_d  [1:S];

  logic             out_valid_q, out_valid_d;
  logic [2*W-1:0]   out_p_q, out_p_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             stall;
  logic             advance;
  logic [W-1:0]     hi_sum;
  logic [W-1:0]     row_lsb;
  logic [W-1:0]     stg_sum [1:S];
  logic [W-1:0]     stg_cry [1:S];

  // Adder array: rows chain inside a stage and restart from registers at each stage boundary.
  for (genvar j = 0; j < W; j++) begin : g_row
    localparam int K = j / RPS;
    logic [W-1:0] s_in, c_in, s_out, c_out;
    logic         lsb;

    if (j == 0) begin : g_first
      assign s_in = '0;
      assign c_in = '0;
    end else if ((j % RPS) == 0) begin : g_stage_in
      assign s_in = sum_q[K];
      assign c_in = cry_q[K];
    end else begin : g_chain
      assign s_in = g_row[j-1].s_out;
      assign c_in = g_row[j-1].c_out;
    end

    braun_row #(.W(W), .ROW(j)) u_row (
      .pp_i  (a_q[K] & {W{b_q[K][j]}}),
      .sgn_i (sgn_q[K]),
      .sum_i (s_in),
      .cry_i (c_in),
      .sum_o (s_out),
      .cry_o (c_out),
      .lsb_o (lsb)
    );

    assign row_lsb[j] = lsb;

    if ((j % RPS) == RPS - 1) begin : g_stage_out
      assign stg_sum[K+1] = s_out;
      assign stg_cry[K+1] = c_out;
    end
  end

  // Next-state for every stage, stall detection and the final ripple adder.
  always_comb begin
    stall   = out_valid_q && !out_ready;
    advance = !stall;

    vld_d[0] = in_valid;
    a_d[0]   = in_a;
    b_d[0]   = in_b;
    sgn_d[0] = in_signed;
    tag_d[0] = in_tag;
    for (int k = 1; k < S; k++) begin
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      sgn_d[k] = sgn_q[k-1];
    end
    for (int k = 1; k <= S; k++) begin
      vld_d[k] = vld_q[k-1];
      tag_d[k] = tag_q[k-1];
      sum_d[k] = stg_sum[k];
      cry_d[k] = stg_cry[k];
    end

    lo_d[1] = '0;
    for (int k = 2; k <= S; k++) begin
      lo_d[k] = lo_q[k-1];
    end
    for (int k = 1; k <= S; k++) begin
      for (int r = 0; r < RPS; r++) begin
        lo_d[k][(k-1)*RPS + r] = row_lsb[(k-1)*RPS + r];
      end
    end

    hi_sum      = sum_q[S] + cry_q[S];
    out_valid_d = vld_q[S];
    out_p_d     = out_p_q;
    out_tag_d   = out_tag_q;
    if (vld_q[S]) begin
      out_p_d   = {hi_sum, lo_q[S]};
      out_tag_d = tag_q[S];
    end
  end

  // Valid bits and output register: cleared by reset, frozen while stalled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      for (int k = 0; k <= S; k++) vld_q[k] <= 1'b0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_tag_q   <= '0;
    end else if (advance) begin
      for (int k = 0; k <= S; k++) vld_q[k] <= vld_d[k];
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      out_tag_q   <= out_tag_d;
    end
  end

  // Datapath registers advance with the pipe.
  always_ff @(posedge clk) begin
    // NOTE: data registers have no reset; the valid bits alone say whether their contents matter.
    if (advance) begin
      for (int k = 0; k < S; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sgn_q[k] <= sgn_d[k];
      end
      for (int k = 0; k <= S; k++) tag_q[k] <= tag_d[k];
      for (int k = 1; k <= S; k++) begin
        sum_q[k] <= sum_d[k];
        cry_q[k] <= cry_d[k];
        lo_q[k]  <= lo_d[k];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_braun_mult_pipe.sv
// Self-checking bench for braun_mult_pipe at W=8, ROWS_PER_STAGE=2 (latency 5).
module tb_braun_mult_pipe;

  localparam int W     = 8;
  localparam int RPS   = 2;
  localparam int TAG_W = 4;
  localparam int LAT   = 5;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic [2*W-1:0] p;
  } vec_t;

  typedef struct {
    logic [2*W-1:0]   p;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_signed;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_p;
  logic [TAG_W-1:0] out_tag;

  int               n_checks;
  int               n_fail;
  exp_t             exp_q[$];
  logic [2*W-1:0]   drv_exp;
  bit               last_fin;
  vec_t             vecs[16];

  braun_mult_pipe #(.W(W), .ROWS_PER_STAGE(RPS), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference product: extend both operands to 2W bits, multiply modulo 2^2W.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [2*W-1:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  // One clock: record the beats that fire at the coming edge, then step past it.
  task automatic cycle();
    exp_t e;
    bit   fin, fout;
    #1;
    fin  = in_valid && in_ready && !rst;
    fout = out_valid && out_ready && !rst;
    if (fout) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_p", out_p, e.p);
        check("out_tag", out_tag, e.tag);
      end
    end
    if (fin) exp_q.push_back('{p: drv_exp, tag: in_tag});
    last_fin = fin;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [TAG_W-1:0] t, input logic [2*W-1:0] e);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = t;
    drv_exp   = e;
  endtask

  task automatic drive_op(input int idx);
    logic [W-1:0] a, b;
    logic         s;
    a = W'(idx * 37 + 11);
    b = W'(idx * 59 + 200);
    s = idx[0];
    drive(a, b, s, TAG_W'(idx), model(a, b, s));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle();
    check("drain_left", exp_q.size(), 0);
    repeat (3) cycle();
  endtask

  initial begin
    int lat, idx, guard, issued, cyc;

    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{8'd100, 8'd200, 1'b0, 16'h4E20};
    vecs[1]  = '{8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[2]  = '{8'hFF,  8'h01,  1'b1, 16'hFFFF};
    vecs[3]  = '{8'h7F,  8'h80,  1'b1, 16'hC080};
    vecs[4]  = '{8'h00,  8'hFB,  1'b1, 16'h0000};
    vecs[5]  = '{8'd0,   8'd0,   1'b1, 16'd0};
    vecs[6]  = '{8'd1,   8'd1,   1'b0, 16'd1};
    vecs[7]  = '{8'd15,  8'd15,  1'b1, 16'd225};
    vecs[8]  = '{8'd255, 8'd1,   1'b0, 16'd255};
    vecs[9]  = '{8'd1,   8'd255, 1'b0, 16'd255};
    vecs[10] = '{8'd16,  8'd16,  1'b1, 16'd256};
    vecs[11] = '{8'd255, 8'd255, 1'b0, 16'd65025};
    vecs[12] = '{8'd100, 8'd200, 1'b0, 16'd20000};
    vecs[13] = '{8'd85,  8'd51,  1'b1, 16'd4335};
    vecs[14] = '{8'd128, 8'd64,  1'b0, 16'd8192};
    vecs[15] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    in_tag = '0; out_ready = 1'b1; drv_exp = '0; last_fin = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    cycle();

    // Latency of a single unsigned max*max op
    drive(8'hFF, 8'hFF, 1'b0, 4'hA, 16'hFE01);
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check("latency", lat, LAT);
    drain();

    // Table of directed vectors, issued back to back with mixed modes
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].sgn, TAG_W'(i), vecs[i].p);
      cycle();
      check("table_accept", in_ready, 1);
    end
    drain();

    // Backpressure: fill, stall three cycles, release
    out_ready = 1'b1;
    idx = 0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      drive_op(idx);
      cycle();
      if (last_fin) idx++;
      guard++;
    end
    check("bp_fill_out_valid", out_valid, 1);
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive_op(idx);
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      if (exp_q.size() > 0) begin
        check("bp_hold_p", out_p, exp_q[0].p);
        check("bp_hold_tag", out_tag, exp_q[0].tag);
      end
      cycle();
      if (last_fin) idx++;
    end
    out_ready = 1'b1;
    while (idx < 12 && guard < 80) begin
      drive_op(idx);
      cycle();
      if (last_fin) idx++;
      guard++;
    end
    check("bp_issued", idx, 12);
    drain();

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      drive_op(i + 20);
      cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_q.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      check("midrst_stale", out_valid, 0);
      cycle();
    end

    // Random traffic against the reference model
    issued = 0;
    cyc = 0;
    while (issued < 10000 && cyc < 60000) begin
      logic [W-1:0] a, b;
      logic         s;
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom_range(0, 1));
      drive(a, b, s, TAG_W'(issued), model(a, b, s));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      if (last_fin) issued++;
      cyc++;
    end
    check("rand_issued", issued, 10000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
